// File: rtl/flag_rf_unit.sv
// ---------------------------------------------------------------------------
// flag_rf_unit
//
// Processor condition-flag register. Holds the Zero (z), Overflow (v) and
// Negative (n) flags produced by the ALU and evaluates the branch condition
// of the current instruction.
//
// The flags are captured one clock after an arithmetic/logic instruction
// (ADD, SUB, NAND, XOR, INC). The branch-taken output is purely
// combinational from the stored flags and the instruction word. There is no
// forwarding: a B instruction sees the flags stored before the current edge.
//
// Ports:
//   clk    in   1   system clock, rising-edge active
//   rst    in   1   synchronous reset, active-high, clears z/v/n
//   stall  in   1   (only with FLAG_RF_STALL_EN) holds the flags when 1
//   out    out  1   branch taken (opcode B and condition satisfied)
//   alu_z  in   1   ALU zero flag
//   alu_v  in   1   ALU signed-overflow flag
//   alu_n  in   1   ALU negative flag
//   instr  in   16  current instruction word
//
// Configuration macro:
//   FLAG_RF_STALL_EN  adds the stall input; when undefined the port is absent
//                     and updates follow the opcode rules only.
// ---------------------------------------------------------------------------
module flag_rf_unit (
    input  logic        clk,
    input  logic        rst,
`ifdef FLAG_RF_STALL_EN
    input  logic        stall,
`endif
    output logic        out,
    input  logic        alu_z,
    input  logic        alu_v,
    input  logic        alu_n,
    input  logic [15:0] instr
);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_NAND = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_INC  = 4'b0100;
    localparam logic [3:0] OP_B    = 4'b1100;

    localparam logic [2:0] CC_NE  = 3'b000;
    localparam logic [2:0] CC_EQ  = 3'b001;
    localparam logic [2:0] CC_GT  = 3'b010;
    localparam logic [2:0] CC_LT  = 3'b011;
    localparam logic [2:0] CC_GE  = 3'b100;
    localparam logic [2:0] CC_LE  = 3'b101;
    localparam logic [2:0] CC_OVF = 3'b110;
    localparam logic [2:0] CC_UNC = 3'b111;

    logic       z;
    logic       v;
    logic       n;

    logic [3:0] opcode;
    logic [2:0] cond;
    logic       flag_op;
    logic       upd_en;

    assign opcode = instr[15:12];
    assign cond   = instr[10:8];

    // Only the ALU arithmetic/logic group writes the flags. An X opcode
    // matches no item and therefore falls to the default (no update).
    always_comb begin
        flag_op = 1'b0;
        case (opcode)
            OP_ADD, OP_SUB, OP_NAND, OP_XOR, OP_INC: flag_op = 1'b1;
            default:                                 flag_op = 1'b0;
        endcase
    end

`ifdef FLAG_RF_STALL_EN
    assign upd_en = flag_op & ~stall;
`else
    assign upd_en = flag_op;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            z <= 1'b0;
            v <= 1'b0;
            n <= 1'b0;
        end else if (upd_en) begin
            z <= alu_z;
            v <= alu_v;
            n <= alu_n;
        end
    end

    // Signed comparisons use n^v as "less than" so the result stays correct
    // when the subtraction that set the flags overflowed.
    function automatic logic cond_met(input logic [2:0] cc,
                                      input logic       fz,
                                      input logic       fv,
                                      input logic       fn);
        logic lt;
        lt = fn ^ fv;
        case (cc)
            CC_NE:   cond_met = ~fz;
            CC_EQ:   cond_met = fz;
            CC_GT:   cond_met = ~fz & ~lt;
            CC_LT:   cond_met = lt;
            CC_GE:   cond_met = fz | ~lt;
            CC_LE:   cond_met = fz | lt;
            CC_OVF:  cond_met = fv;
            CC_UNC:  cond_met = 1'b1;
            default: cond_met = 1'b0;
        endcase
    endfunction

    always_comb begin
        out = 1'b0;
        if (opcode == OP_B) begin
            out = cond_met(cond, z, v, n);
        end
    end

endmodule

// File: tb/tb_flag_rf_unit.sv
// ---------------------------------------------------------------------------
// tb_flag_rf_unit
//
// Directed bench for flag_rf_unit. Each task drives one scenario and checks
// the flags (read hierarchically) and the branch-taken output against
// hand-computed values. Inputs change 1 time unit after the rising edge so
// they are stable well before the next edge.
// ---------------------------------------------------------------------------
module tb_flag_rf_unit;

    logic        clk;
    logic        rst;
`ifdef FLAG_RF_STALL_EN
    logic        stall;
`endif
    logic        out;
    logic        alu_z;
    logic        alu_v;
    logic        alu_n;
    logic [15:0] instr;

    int checks;
    int failures;

    flag_rf_unit dut (
        .clk   (clk),
        .rst   (rst),
`ifdef FLAG_RF_STALL_EN
        .stall (stall),
`endif
        .out   (out),
        .alu_z (alu_z),
        .alu_v (alu_v),
        .alu_n (alu_n),
        .instr (instr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] mk(input logic [3:0] op, input logic [2:0] cc);
        mk = {op, 1'b0, cc, 8'h00};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Load the flags through a real ADD so no hierarchical write is needed.
    task automatic set_flags(input logic [2:0] zvn);
        instr = mk(4'b0000, 3'b000);
        alu_z = zvn[2];
        alu_v = zvn[1];
        alu_n = zvn[0];
        tick();
        alu_z = 1'b0;
        alu_v = 1'b0;
        alu_n = 1'b0;
    endtask

    task automatic test_reset;
        set_flags(3'b111);
        checks++;
        if ({dut.z, dut.v, dut.n} !== 3'b111) begin
            failures++;
            $display("FAIL preset_111 got=%b exp=111", {dut.z, dut.v, dut.n});
        end
        instr = mk(4'b0000, 3'b000);
        alu_z = 1'b1; alu_v = 1'b1; alu_n = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        alu_z = 1'b0; alu_v = 1'b0; alu_n = 1'b0;
        checks++;
        if ({dut.z, dut.v, dut.n} !== 3'b000) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=000", {dut.z, dut.v, dut.n});
        end
        instr = mk(4'b1100, 3'b001);
        #1;
        checks++;
        if (out !== 1'b0) begin
            failures++;
            $display("FAIL reset_out_eq got=%b exp=0", out);
        end
    endtask

    task automatic test_force_immediate;
        set_flags(3'b100);
        instr = mk(4'b1100, 3'b001);
        #1;
        checks++;
        if (out !== 1'b1) begin
            failures++;
            $display("FAIL eq_z1 got=%b exp=1", out);
        end
        force dut.z = 1'b0;
        #1;
        checks++;
        if (out !== 1'b0) begin
            failures++;
            $display("FAIL eq_forced_z0 got=%b exp=0", out);
        end
        release dut.z;
        set_flags(3'b000);
    endtask

    // {z,v,n} pattern, condition code, expected out
    task automatic test_conditions;
        logic [2:0] tz [14];
        logic [2:0] tc [14];
        logic       te [14];
        tz = '{3'b001, 3'b000, 3'b011,
               3'b000, 3'b001, 3'b010,
               3'b000, 3'b001, 3'b010, 3'b100,
               3'b000, 3'b010, 3'b101, 3'b000};
        tc = '{3'b011, 3'b011, 3'b011,
               3'b010, 3'b010, 3'b010,
               3'b100, 3'b100, 3'b100, 3'b100,
               3'b000, 3'b110, 3'b101, 3'b111};
        te = '{1'b1, 1'b0, 1'b0,
               1'b1, 1'b0, 1'b0,
               1'b1, 1'b0, 1'b0, 1'b1,
               1'b1, 1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 14; i++) begin
            set_flags(tz[i]);
            instr = mk(4'b1100, tc[i]);
            instr[11]  = 1'bx;
            instr[7:0] = 8'hxx;
            #1;
            checks++;
            if (out !== te[i]) begin
                failures++;
                $display("FAIL cond_%0d zvn=%b cc=%b got=%b exp=%b",
                         i, tz[i], tc[i], out, te[i]);
            end
        end
        // Non-branch opcode with an always-true condition field
        set_flags(3'b100);
        instr = mk(4'b1101, 3'b111);
        #1;
        checks++;
        if (out !== 1'b0) begin
            failures++;
            $display("FAIL non_b_out got=%b exp=0", out);
        end
    endtask

    task automatic test_update_opcodes;
        for (int op = 0; op < 15; op++) begin
            logic [2:0] exp;
            set_flags(3'b111);
            instr = mk(op[3:0], 3'b000);
            alu_z = 1'b0; alu_v = 1'b0; alu_n = 1'b0;
            tick();
            exp = (op <= 4) ? 3'b000 : 3'b111;
            checks++;
            if ({dut.z, dut.v, dut.n} !== exp) begin
                failures++;
                $display("FAIL update_op%0d got=%b exp=%b", op, {dut.z, dut.v, dut.n}, exp);
            end
        end
        // Mixed values land on the right flags
        set_flags(3'b000);
        instr = mk(4'b0001, 3'b000);
        alu_z = 1'b0; alu_v = 1'b1; alu_n = 1'b0;
        tick();
        checks++;
        if ({dut.z, dut.v, dut.n} !== 3'b010) begin
            failures++;
            $display("FAIL sub_010 got=%b exp=010", {dut.z, dut.v, dut.n});
        end
    endtask

    task automatic test_hold_and_no_forward;
        set_flags(3'b100);
        instr = mk(4'b1100, 3'b001);
        alu_z = 1'b0; alu_v = 1'b1; alu_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({dut.z, dut.v, dut.n, out} !== 4'b1001) begin
                failures++;
                $display("FAIL hold_%0d got=%b exp=1001", i, {dut.z, dut.v, dut.n, out});
            end
        end
        // ALU inputs never reach out directly
        alu_z = 1'b1;
        set_flags(3'b000);
        instr = mk(4'b1100, 3'b001);
        alu_z = 1'b1;
        #1;
        checks++;
        if (out !== 1'b0) begin
            failures++;
            $display("FAIL no_forward got=%b exp=0", out);
        end
        alu_z = 1'b0;
    endtask

`ifdef FLAG_RF_STALL_EN
    task automatic test_stall;
        set_flags(3'b100);
        stall = 1'b1;
        instr = mk(4'b0000, 3'b000);
        alu_z = 1'b0; alu_v = 1'b0; alu_n = 1'b0;
        tick();
        checks++;
        if ({dut.z, dut.v, dut.n} !== 3'b100) begin
            failures++;
            $display("FAIL stall_hold got=%b exp=100", {dut.z, dut.v, dut.n});
        end
        instr = mk(4'b1100, 3'b001);
        #1;
        checks++;
        if (out !== 1'b1) begin
            failures++;
            $display("FAIL stall_out got=%b exp=1", out);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({dut.z, dut.v, dut.n} !== 3'b000) begin
            failures++;
            $display("FAIL stall_reset got=%b exp=000", {dut.z, dut.v, dut.n});
        end
        stall = 1'b0;
    endtask
`endif

    initial begin
        checks   = 0;
        failures = 0;
        rst   = 1'b1;
`ifdef FLAG_RF_STALL_EN
        stall = 1'b0;
`endif
        alu_z = 1'b0;
        alu_v = 1'b0;
        alu_n = 1'b0;
        instr = 16'h0000;
        tick();
        rst = 1'b0;

        test_reset();
        test_force_immediate();
        test_conditions();
        test_update_opcodes();
        test_hold_and_no_forward();
`ifdef FLAG_RF_STALL_EN
        test_stall();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/flag_rf_unit.md
Name: flag_rf_unit

Overview:
- Processor condition-flag register: holds Zero (z), Overflow (v) and Negative (n) flags.
- Captures the ALU flag outputs for arithmetic/logic instructions.
- Combinationally evaluates the branch condition of the current instruction.
- Sits between the execute stage (ALU flags) and the PC/branch logic (taken signal).

Parameters:
- None. Instruction width is fixed at 16 and opcode width at 4.

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- rst  input  1  synchronous reset, active-high; sampled on the rising edge of clk
- out  output 1  branch-taken; 1 when the current instruction is B and its condition is satisfied by the stored flags
- alu_z  input  1  ALU zero result flag
- alu_v  input  1  ALU signed-overflow flag
- alu_n  input  1  ALU negative (result MSB) flag
- instr  input  16  current instruction word

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- State is three 1-bit registers named exactly z, v and n. Verification reads and forces them hierarchically.
- Instruction fields:
  - opcode = instr[15:12]
  - instr[11] is don't-care
  - condition code = instr[10:8]
  - instr[7:0] is don't-care for this block
- Opcodes:
  - ADD=0000, SUB=0001, NAND=0010, XOR=0011, INC=0100
  - SRA=0101, SRL=0110, SLL=0111
  - SW=1000, LW=1001, LHB=1010, LLB=1011
  - B=1100, CALL=1101, RET=1110, HLT=1111
- Reset: on a rising clk edge with rst=1, z, v and n all become 0. Reset takes priority over any update.
- Flag update, 1-cycle latency: on a rising clk edge with rst=0 and opcode in {ADD, SUB, NAND, XOR, INC}:
  - z<=alu_z, v<=alu_v, n<=alu_n, all three together.
  - The ALU is responsible for driving v=0 on NAND and XOR.
- All other opcodes leave all three flags unchanged. This covers shifts, memory ops, LHB, LLB, B, CALL, RET, HLT and any X opcode.
- out is purely combinational from the current flag registers and instr; there are no clock cycles of latency.
  - If opcode != B, out=0.
  - If opcode == B, out is selected by the condition code:
    - 000 NOT_EQUAL: ~z
    - 001 EQUAL: z
    - 010 GREATER: ~z & ~(n^v)
    - 011 LESS: n^v
    - 100 GREATER_OR_EQUAL: z | ~(n^v)
    - 101 LESS_OR_EQUAL: z | (n^v)
    - 110 OVERFLOW: v
    - 111 UNCONDITIONAL: 1
- Flag changes (update, reset or hierarchical force) are reflected on out immediately.
- A B instruction uses the flags stored before the current edge; there is no forwarding from alu_* to out.
- The out expression must be X-free whenever opcode, the condition code and the flags are known. Don't-care bits instr[11] and instr[7:0] may be X.

Optional Feature:
- Macro FLAG_RF_STALL_EN.
- Defined: adds input port stall (1 bit, placed after rst). When stall=1, flag updates are suppressed and z/v/n hold, even for ADD..INC. Reset still applies during a stall. out is unaffected by stall.
- Undefined: the port is absent and updates follow the opcode rules only.

Test Plan:
- Reset with flags at 1/1/1, rst=1 for one edge -> z=v=n=0; with instr=B/EQUAL, out=0.
- Force z=1,v=0,n=0, instr=B/EQUAL -> out=1; then force z=0 -> out=0, with no clock edge in between.
- B/LESS with {z,v,n}: 001 -> 1; 000 -> 0; 011 -> 0.
- B/GREATER: 000 -> 1, 001 -> 0, 010 -> 0. B/GREATER_OR_EQUAL: 000 -> 1, 001 -> 0, 010 -> 0, 100 -> 1.
- Flags preset to 1/1/1, alu_*=0, one edge per opcode:
  - ADD, SUB, NAND, XOR, INC -> flags 0/0/0.
  - SRA, SRL, SLL, SW, LW, LHB, LLB, B, CALL, RET -> flags stay 1/1/1.
- Flags z=1,v=0,n=0 and instr=B/EQUAL held across edges -> flags unchanged and out stays 1. With FLAG_RF_STALL_EN and stall=1, ADD with alu_*=0 -> flags hold 1/0/0.
